// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS sequencer and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic             bcond;
    logic             mem_ready;
    logic             pc_write;
    logic             ir_write;
    logic             reg_dst;
    logic             jump;
    logic             branch;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic             reg_write;
    logic             alu_ctl_op;
    logic [2:0]       state;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, bcond, mem_ready,
        output pc_write, ir_write, reg_dst, jump, branch, mem_read, mem_write,
               mem_to_reg, alu_src, reg_write, alu_ctl_op, state, halted,
               illegal, retired
    );

    modport slave (
        output opcode, bcond, mem_ready,
        input  pc_write, ir_write, reg_dst, jump, branch, mem_read, mem_write,
               mem_to_reg, alu_src, reg_write, alu_ctl_op, state, halted,
               illegal, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: steps each instruction through IF/ID/EX/MEM/WB,
// drives datapath enables, counts retired instructions and flags bad opcodes.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ir_write;
        logic reg_dst;
        logic jump;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic reg_write;
        logic alu_ctl_op;
        logic halted;
        logic illegal;
    } ctl_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    ctl_t             ctl, ctl_g;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        ctl     = '0;
        case (state_q)
            S_IF: begin
                ctl.ir_write = 1'b1;
                state_d      = S_ID;
            end
            S_ID: begin
                case (bus.opcode)
                    OP_J: begin
                        ctl.jump     = 1'b1;
                        ctl.pc_write = 1'b1;
                        retire       = 1'b1;
                        state_d      = S_IF;
                    end
                    OP_HALT: state_d = S_HALT;
                    OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: state_d = S_EX;
                    default: begin
                        ctl.pc_write = 1'b1;
                        ctl.illegal  = 1'b1;
                        state_d      = S_IF;
                    end
                endcase
            end
            S_EX: begin
                case (bus.opcode)
                    OP_R: begin
                        ctl.alu_ctl_op = 1'b1;
                        state_d        = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        ctl.alu_src = 1'b1;
                        state_d     = S_MEM;
                    end
                    OP_ADDI: begin
                        ctl.alu_src = 1'b1;
                        state_d     = S_WB;
                    end
                    OP_BEQ: begin
                        ctl.branch   = 1'b1;
                        ctl.pc_write = 1'b1;
                        retire       = 1'b1;
                        state_d      = S_IF;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM: begin
                // Strobes are held every wait cycle; only completion advances.
                case (bus.opcode)
                    OP_LW: begin
                        ctl.alu_src  = 1'b1;
                        ctl.mem_read = 1'b1;
                        if (bus.mem_ready) state_d = S_WB;
                    end
                    OP_SW: begin
                        ctl.alu_src   = 1'b1;
                        ctl.mem_write = 1'b1;
                        if (bus.mem_ready) begin
                            ctl.pc_write = 1'b1;
                            retire       = 1'b1;
                            state_d      = S_IF;
                        end
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_WB: begin
                state_d = S_IF;
                case (bus.opcode)
                    OP_R: begin
                        ctl.reg_dst    = 1'b1;
                        ctl.alu_ctl_op = 1'b1;
                        ctl.reg_write  = 1'b1;
                        ctl.pc_write   = 1'b1;
                        retire         = 1'b1;
                    end
                    OP_ADDI: begin
                        ctl.alu_src   = 1'b1;
                        ctl.reg_write = 1'b1;
                        ctl.pc_write  = 1'b1;
                        retire        = 1'b1;
                    end
                    OP_LW: begin
                        ctl.mem_to_reg = 1'b1;
                        ctl.reg_write  = 1'b1;
                        ctl.pc_write   = 1'b1;
                        retire         = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: ctl.halted = 1'b1;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IF;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Reset forces every output low for the reset cycle, whatever the old state.
    assign ctl_g          = rst ? '0 : ctl;
    assign bus.pc_write   = ctl_g.pc_write;
    assign bus.ir_write   = ctl_g.ir_write;
    assign bus.reg_dst    = ctl_g.reg_dst;
    assign bus.jump       = ctl_g.jump;
    assign bus.branch     = ctl_g.branch;
    assign bus.mem_read   = ctl_g.mem_read;
    assign bus.mem_write  = ctl_g.mem_write;
    assign bus.mem_to_reg = ctl_g.mem_to_reg;
    assign bus.alu_src    = ctl_g.alu_src;
    assign bus.reg_write  = ctl_g.reg_write;
    assign bus.alu_ctl_op = ctl_g.alu_ctl_op;
    assign bus.halted     = ctl_g.halted;
    assign bus.illegal    = ctl_g.illegal;
    assign bus.state      = rst ? 3'd0 : state_q;
    assign bus.retired    = rst ? '0 : retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction signal profiles from a
// table model, checked by a negedge monitor; a CNT_W=2 twin checks wrap.
module tb_multicycle_ctrl;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam int NC = 11;

    typedef struct {
        logic [5:0] op;
        int         w;
    } instr_t;

    typedef struct {
        int          c[NC];
        bit          halt;
        logic [31:0] ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(32)) bus1 ();
    multicycle_ctrl_if #(.CNT_W(2))  bus2 ();

    assign bus2.opcode    = bus1.opcode;
    assign bus2.bcond     = bus1.bcond;
    assign bus2.mem_ready = bus1.mem_ready;

    multicycle_ctrl #(.CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus1));
    multicycle_ctrl #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int          total = 0;
    int          bad = 0;
    exp_t        exp_q[$];
    instr_t      prog[$];
    logic [31:0] model_cnt = 0;
    logic [5:0]  cur_op;
    int          cur_w = 0;
    int          waited = 0;

    task automatic check(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic string cname(input int i);
        case (i)
            0: return "cycles";
            1: return "mem_read_cycles";
            2: return "mem_write_cycles";
            3: return "reg_write_cycles";
            4: return "jump_cycles";
            5: return "branch_cycles";
            6: return "illegal_cycles";
            7: return "alu_src_cycles";
            8: return "alu_ctl_op_cycles";
            9: return "reg_dst_cycles";
            default: return "mem_to_reg_cycles";
        endcase
    endfunction

    function automatic bit is_defined(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_HALT};
    endfunction

    // How many cycles each signal is high per instruction, from the timing table.
    function automatic exp_t model(input logic [5:0] op, input int w, input logic [31:0] cnt);
        exp_t e;
        for (int i = 0; i < NC; i++) e.c[i] = 0;
        e.halt = 1'b0;
        e.ret  = cnt;
        case (op)
            OP_R:    begin e.c[0] = 4;     e.c[3] = 1;     e.c[8] = 2; e.c[9] = 1; end
            OP_LW:   begin e.c[0] = 5 + w; e.c[1] = w + 1; e.c[3] = 1; e.c[7] = w + 2; e.c[10] = 1; end
            OP_SW:   begin e.c[0] = 4 + w; e.c[2] = w + 1; e.c[7] = w + 2; end
            OP_BEQ:  begin e.c[0] = 3;     e.c[5] = 1; end
            OP_J:    begin e.c[0] = 2;     e.c[4] = 1; end
            OP_ADDI: begin e.c[0] = 4;     e.c[3] = 1;     e.c[7] = 2; end
            OP_HALT: begin e.c[0] = 3;     e.halt = 1'b1; end
            default: begin e.c[0] = 2;     e.c[6] = 1; end
        endcase
        return e;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        t.w = int'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
            0: t.op = OP_R;
            1: t.op = OP_LW;
            2: t.op = OP_SW;
            3: t.op = OP_BEQ;
            4: t.op = OP_J;
            5: t.op = 6'($urandom_range(16, 31));
            default: t.op = OP_ADDI;
        endcase
        return t;
    endfunction

    function automatic logic [11:0] enables();
        return {bus1.pc_write, bus1.ir_write, bus1.reg_dst, bus1.jump, bus1.branch,
                bus1.mem_read, bus1.mem_write, bus1.mem_to_reg, bus1.alu_src,
                bus1.reg_write, bus1.alu_ctl_op, bus1.illegal};
    endfunction

    // Driver: one clock per call, inputs changed 1 time unit after the edge.
    task automatic step();
        instr_t t;
        exp_t   e;
        @(posedge clk);
        #1;
        bus1.bcond = 1'($urandom);
        case (bus1.state)
            3'd0: begin
                bus1.opcode    = 6'($urandom);
                bus1.mem_ready = 1'($urandom);
            end
            3'd1: begin
                t = (prog.size() != 0) ? prog.pop_front() : rand_instr();
                cur_op = t.op;
                cur_w  = t.w;
                waited = 0;
                e = model(t.op, t.w, model_cnt);
                exp_q.push_back(e);
                if (is_defined(t.op) && t.op != OP_HALT) model_cnt = model_cnt + 1;
                bus1.opcode    = cur_op;
                bus1.mem_ready = 1'($urandom);
            end
            3'd3: begin
                bus1.mem_ready = (waited >= cur_w);
                waited++;
            end
            default: bus1.mem_ready = 1'($urandom);
        endcase
    endtask

    task automatic run_prog();
        int guard = 0;
        while ((prog.size() != 0 || exp_q.size() != 0) && guard < 4000) begin
            step();
            guard++;
        end
        if (guard >= 4000) check("prog_timeout", guard, 0);
    endtask

    // Monitor: accumulates each instruction's window and scores it at pc_write/halt.
    bit win = 1'b0;
    int acc[NC];
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            win = 1'b0;
            check("reset_outputs_zero",
                  {enables(), bus1.halted, bus1.state, bus1.retired, bus2.retired}, 0);
        end else begin
            if (bus1.ir_write) begin
                check("ir_write_in_if", bus1.state, 0);
                win = 1'b1;
                for (int i = 0; i < NC; i++) acc[i] = 0;
            end
            if (win) begin
                acc[0]++;
                acc[1]  += int'(bus1.mem_read);
                acc[2]  += int'(bus1.mem_write);
                acc[3]  += int'(bus1.reg_write);
                acc[4]  += int'(bus1.jump);
                acc[5]  += int'(bus1.branch);
                acc[6]  += int'(bus1.illegal);
                acc[7]  += int'(bus1.alu_src);
                acc[8]  += int'(bus1.alu_ctl_op);
                acc[9]  += int'(bus1.reg_dst);
                acc[10] += int'(bus1.mem_to_reg);
                if (bus1.pc_write || bus1.halted) begin
                    win = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        for (int i = 0; i < NC; i++) check(cname(i), acc[i], e.c[i]);
                        check("halted_at_end", bus1.halted, e.halt);
                        check("retired", bus1.retired, e.ret);
                        check("retired_w2", bus2.retired, e.ret[1:0]);
                    end
                end
            end else begin
                check("idle_halted", bus1.halted, 1);
                check("idle_state", bus1.state, 5);
                check("idle_enables", enables(), 0);
            end
        end
    end

    initial begin
        instr_t t;
        int     guard;
        bus1.opcode    = '0;
        bus1.bcond     = 1'b0;
        bus1.mem_ready = 1'b0;

        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_state", bus1.state, 0);
        check("post_reset_retired", bus1.retired, 0);
        check("post_reset_halted", bus1.halted, 0);
        check("post_reset_illegal", bus1.illegal, 0);

        t.op = OP_R;          t.w = 0; prog.push_back(t);
        t.op = OP_LW;         t.w = 3; prog.push_back(t);
        t.op = OP_BEQ;        t.w = 0; prog.push_back(t);
        t.op = OP_BEQ;        t.w = 0; prog.push_back(t);
        t.op = OP_J;          t.w = 0; prog.push_back(t);
        t.op = 6'b111110;     t.w = 0; prog.push_back(t);
        t.op = OP_SW;         t.w = 2; prog.push_back(t);
        for (int i = 0; i < 5; i++) begin
            t.op = OP_ADDI; t.w = 0; prog.push_back(t);
        end
        for (int i = 0; i < 150; i++) prog.push_back(rand_instr());
        t.op = OP_HALT; t.w = 0; prog.push_back(t);
        run_prog();
        repeat (20) step();

        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        check("halt_reset_state", bus1.state, 0);
        check("halt_reset_halted", bus1.halted, 0);
        check("halt_reset_retired", bus1.retired, 0);

        t.op = OP_ADDI; t.w = 0; prog.push_back(t);
        t.op = OP_SW;   t.w = 6; prog.push_back(t);
        guard = 0;
        while (!(bus1.state == 3'd3 && cur_op == OP_SW) && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) check("sw_mem_timeout", guard, 0);
        step();
        rst = 1'b1;
        exp_q.delete();
        prog.delete();
        model_cnt = 0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midmem_reset_state", bus1.state, 0);
        check("midmem_reset_mem_write", bus1.mem_write, 0);
        check("midmem_reset_retired", bus1.retired, 0);

        t.op = OP_LW; t.w = 0; prog.push_back(t);
        t.op = OP_R;  t.w = 0; prog.push_back(t);
        for (int i = 0; i < 20; i++) prog.push_back(rand_instr());
        run_prog();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
